// File: rtl/status_led_pkg.sv
// Shared constants for the status LED controller.
// - Per-channel mode encodings.
// - A helper that extracts channel i's 2-bit mode field from the packed ch_mode bus.
package status_led_pkg;

  // Upper bound on the channel count that mode_of can index.
  localparam int unsigned MAX_CH = 32;

  localparam logic [1:0] MODE_FOLLOW = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_LATCH  = 2'b11;

  // Returns bits [2*idx+1:2*idx] of modes.
  // A shift is used instead of an indexed part-select so that no index-width
  // truncation occurs.
  function automatic logic [1:0] mode_of(input logic [2*MAX_CH-1:0] modes,
                                         input int unsigned          idx);
    logic [2*MAX_CH-1:0] sh;
    sh = modes >> (2 * idx);
    return sh[1:0];
  endfunction

endpackage

// File: rtl/status_led_ctrl_if.sv
// Bus between the status LED controller and its user.
// - master: drives ch_in, ch_mode and ack; observes the indicator outputs.
// - slave:  the controller itself.
interface status_led_ctrl_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0]   ch_in;      // raw asynchronous status inputs, active-high
  logic [2*NUM_CH-1:0] ch_mode;    // 2-bit mode per channel, quasi-static
  logic                ack;        // single-cycle alarm acknowledge
  logic [NUM_CH-1:0]   ch_stable;  // debounced channel levels
  logic [NUM_CH-1:0]   led;        // registered LED drive
  logic                alarm_any;  // any latched alarm
  logic                buzzer;     // alarm_any gated by blink phase

  modport master (
    output ch_in, ch_mode, ack,
    input  ch_stable, led, alarm_any, buzzer
  );

  modport slave (
    input  ch_in, ch_mode, ack,
    output ch_stable, led, alarm_any, buzzer
  );
endinterface

// File: rtl/status_ch_filter.sv
// One status channel: two-flop synchroniser followed by a debounce filter.
// The stable level flips only after the synchronised input has disagreed with it
// for FILT_CNT consecutive cycles.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   ch_i      - raw asynchronous input
//   stable_o  - debounced level
module status_ch_filter #(
  parameter int unsigned FILT_CNT = 50000,
  parameter int unsigned FILT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ch_i,
  output logic stable_o
);

  localparam logic [FILT_W-1:0] CntLast = FILT_W'(FILT_CNT - 1);

  logic              sync1_q, sync2_q;
  logic              stable_q, stable_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= ch_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/status_led_ctrl.sv
// N-channel status indicator.
// - Each channel is synchronised and debounced.
// - The debounced level drives its LED in one of four modes: follow, invert,
//   blink, or latched alarm.
// - Latched alarms raise alarm_any and an intermittent buzzer until ack.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - slave side of status_led_ctrl_if
//               (ch_in, ch_mode, ack in; ch_stable, led, alarm_any, buzzer out)
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FILT_CNT  = 50000,
  parameter int unsigned FILT_W    = 16,
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned DIV_W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  status_led_ctrl_if.slave   bus
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(BLINK_DIV - 1);

  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] stable_prev_q;
  logic [NUM_CH-1:0] latch_q, latch_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              blink_q, blink_d;
  logic              alarm_q, buzzer_q;
  logic [1:0]        mode;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    status_ch_filter #(
      .FILT_CNT (FILT_CNT),
      .FILT_W   (FILT_W)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .ch_i     (bus.ch_in[i]),
      .stable_o (stable[i])
    );
  end

  // Free-running blink prescaler shared by all channels, keeping them phase-aligned.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    blink_d = blink_q;
    if (div_q == DivLast) begin
      div_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_comb begin
    latch_d = '0;
    led_d   = '0;
    mode    = MODE_FOLLOW;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mode = mode_of((2 * MAX_CH)'(bus.ch_mode), i);
      // The latch exists only in latch mode.
      // A rising edge beats a simultaneous ack.
      if (mode == MODE_LATCH) begin
        latch_d[i] = (stable[i] & ~stable_prev_q[i]) | (latch_q[i] & ~bus.ack);
      end
      unique case (mode)
        MODE_FOLLOW: led_d[i] = stable[i];
        MODE_INVERT: led_d[i] = ~stable[i];
        MODE_BLINK:  led_d[i] = stable[i] & blink_q;
        MODE_LATCH:  led_d[i] = latch_q[i] & blink_q;
        default:     led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      blink_q       <= 1'b0;
      stable_prev_q <= '0;
      latch_q       <= '0;
      led_q         <= '0;
      alarm_q       <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      blink_q       <= blink_d;
      stable_prev_q <= stable;
      latch_q       <= latch_d;
      led_q         <= led_d;
      alarm_q       <= |latch_q;
      buzzer_q      <= (|latch_q) & blink_q;
    end
  end

  assign bus.ch_stable = stable;
  assign bus.led       = led_q;
  assign bus.alarm_any = alarm_q;
  assign bus.buzzer    = buzzer_q;

endmodule

// File: tb/tb_status_led_ctrl.sv
module tb_status_led_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   ecnt;

  always #5 clk = ~clk;

  status_led_ctrl_if #(.NUM_CH(4)) bus_if ();

  status_led_ctrl #(
    .NUM_CH    (4),
    .FILT_CNT  (4),
    .FILT_W    (4),
    .BLINK_DIV (8),
    .DIV_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Edges since reset release.
  // The blink phase after edge k is (k/8) mod 2.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  function automatic logic ph(input int k);
    return ((k / 8) % 2) == 1;
  endfunction

  typedef struct {
    logic [3:0] ch_in;
    logic [7:0] mode;
    int         wait_n;
    logic [3:0] exp_stable;
    logic [3:0] exp_led;
  } vec_t;

  vec_t tbl[12];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  initial begin
    // ch_in, ch_mode, edges to wait, expected ch_stable, expected led
    tbl[0]  = '{4'b0000, 8'h00, 1, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 8'h00, 5, 4'b0000, 4'b0000};  // not yet qualified
    tbl[2]  = '{4'b0001, 8'h00, 1, 4'b0001, 4'b0000};  // stable at +6
    tbl[3]  = '{4'b0001, 8'h00, 1, 4'b0001, 4'b0001};  // led at +7
    tbl[4]  = '{4'b0011, 8'h00, 3, 4'b0001, 4'b0001};  // 3-cycle glitch
    tbl[5]  = '{4'b0001, 8'h00, 1, 4'b0001, 4'b0001};  // one low cycle
    tbl[6]  = '{4'b0011, 8'h00, 3, 4'b0001, 4'b0001};  // second glitch
    tbl[7]  = '{4'b0001, 8'h00, 8, 4'b0001, 4'b0001};
    tbl[8]  = '{4'b0101, 8'h10, 2, 4'b0001, 4'b0101};  // ch2 invert, still low
    tbl[9]  = '{4'b0101, 8'h10, 5, 4'b0101, 4'b0001};  // ch2 high -> led 0
    tbl[10] = '{4'b0101, 8'h50, 1, 4'b0101, 4'b1001};  // ch3 invert too
    tbl[11] = '{4'b0101, 8'h00, 1, 4'b0101, 4'b0101};

    bus_if.ch_in   = '0;
    bus_if.ch_mode = '0;
    bus_if.ack     = 1'b0;

    #2;
    chk4("reset_stable", bus_if.ch_stable, 4'b0000);
    chk4("reset_led", bus_if.led, 4'b0000);
    chk1("reset_alarm", bus_if.alarm_any, 1'b0);
    chk1("reset_buzzer", bus_if.buzzer, 1'b0);
    #10 rst = 1'b0;
    step(1);

    for (int v = 0; v < 12; v++) begin
      bus_if.ch_in   = tbl[v].ch_in;
      bus_if.ch_mode = tbl[v].mode;
      step(tbl[v].wait_n);
      chk4($sformatf("vec%0d_stable", v), bus_if.ch_stable, tbl[v].exp_stable);
      chk4($sformatf("vec%0d_led", v), bus_if.led, tbl[v].exp_led);
    end

    // Blink: ch2 stable high, led[2] follows the shared phase.
    bus_if.ch_mode = 8'h20;
    for (int j = 0; j < 24; j++) begin
      step(1);
      chk1("blink_led2", bus_if.led[2], ph(ecnt - 1));
      chk1("blink_led0", bus_if.led[0], 1'b1);
    end

    // Latch: ch3 high for 10 cycles in latch mode, then low.
    bus_if.ch_mode = 8'hC0;
    bus_if.ch_in   = 4'b1101;
    for (int j = 1; j <= 10; j++) begin
      step(1);
      chk1("latch_alarm_rise", bus_if.alarm_any, j >= 8);
      chk1("latch_buzzer_rise", bus_if.buzzer, (j >= 8) && ph(ecnt - 1));
    end
    bus_if.ch_in = 4'b0101;
    for (int j = 0; j < 30; j++) begin
      step(1);
      chk1("latch_alarm_hold", bus_if.alarm_any, 1'b1);
      chk1("latch_led3", bus_if.led[3], ph(ecnt - 1));
      chk1("latch_buzzer", bus_if.buzzer, ph(ecnt - 1));
    end
    chk4("latch_stable_low", bus_if.ch_stable, 4'b0101);

    // Acknowledge clears the latch; alarm drops one cycle later.
    bus_if.ack = 1'b1;
    step(1);
    bus_if.ack = 1'b0;
    chk1("ack_alarm_lag", bus_if.alarm_any, 1'b1);
    step(1);
    chk1("ack_alarm_clr", bus_if.alarm_any, 1'b0);
    chk1("ack_buzzer_clr", bus_if.buzzer, 1'b0);
    chk1("ack_led3_clr", bus_if.led[3], 1'b0);

    // Collision: ack in the same cycle the new rising edge is seen; set wins.
    bus_if.ch_in = 4'b1101;
    step(6);
    chk4("coll_stable", bus_if.ch_stable, 4'b1101);
    bus_if.ack = 1'b1;
    step(1);
    bus_if.ack = 1'b0;
    step(1);
    chk1("coll_alarm", bus_if.alarm_any, 1'b1);
    step(4);
    chk1("coll_alarm_hold", bus_if.alarm_any, 1'b1);

    // Reset mid-operation: latch active, ch0 filter half-way to falling.
    bus_if.ch_in = 4'b1100;
    step(4);
    chk4("pre_rst_stable", bus_if.ch_stable, 4'b1101);
    #2 rst = 1'b1;
    #1;
    chk4("rst_stable", bus_if.ch_stable, 4'b0000);
    chk4("rst_led", bus_if.led, 4'b0000);
    chk1("rst_alarm", bus_if.alarm_any, 1'b0);
    chk1("rst_buzzer", bus_if.buzzer, 1'b0);
    #2 rst = 1'b0;
    step(5);
    chk4("requal_early", bus_if.ch_stable, 4'b0000);
    step(1);
    chk4("requal_stable", bus_if.ch_stable, 4'b1100);
    step(2);
    chk1("requal_alarm", bus_if.alarm_any, 1'b1);
    chk4("requal_led", bus_if.led, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
